sram_ctrl_if_gen2: RTL and testbench

Parametrised successor to the AHB-to-embedded-SRAM control interface. It sits between the AHB slave front-end (ahbsram_* request bus) and a generic byte-lane SRAM array, and generalises data width, depth and read latency. It adds a memory-busy issue stall, range/size error reporting, and registered read data that is valid in the ack cycle. The SRAM macro is instantiated outside this block.

---
 rtl/sram_ctrl_pkg.sv | 14 +
 rtl/sram_lane_decode.sv | 24 ++
 rtl/sram_ctrl_if_gen2.sv | 102 ++++++++++
 tb/tb_sram_ctrl_if_gen2.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared FSM states, HSIZE codes and parameter legality check
package sram_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, WR, RD, ERR} state_t;

    localparam logic [2:0] BYTE  = 3'd0;
    localparam logic [2:0] HALF  = 3'd1;
    localparam logic [2:0] WORD  = 3'd2;
    localparam logic [2:0] DWORD = 3'd3;

    function automatic bit params_legal(int dwidth, int depth, int rd_latency);
        return (dwidth == 32 || dwidth == 64) && depth >= 2 &&
               depth * (dwidth / 8) <= (1 << 20) && (rd_latency == 1 || rd_latency == 2);
    endfunction
endpackage

// File: rtl/sram_lane_decode.sv
// sram_lane_decode: HSIZE and low address bits to byte-lane mask plus size error
module sram_lane_decode #(
    parameter int NB = 4,
    parameter int LB = $clog2(NB)
) (
    input  logic [2:0]    i_size,
    input  logic [LB-1:0] i_off,
    output logic [NB-1:0] o_mask,
    output logic          o_size_err
);
    logic [31:0] w_bytes;
    logic [31:0] w_base;

    assign o_size_err = int'(i_size) > LB;
    assign w_bytes    = 32'd1 << i_size;
    // misaligned offsets are aligned down to the transfer size
    assign w_base     = 32'(i_off) & ~(w_bytes - 32'd1);

    always_comb begin
        o_mask = '0;
        for (int b = 0; b < NB; b++)
            o_mask[b] = !o_size_err && 32'(b) >= w_base && 32'(b) < w_base + w_bytes;
    end
endmodule

// File: rtl/sram_ctrl_if_gen2.sv
// sram_ctrl_if_gen2: AHB-side SRAM request FSM with byte lanes, busy stall,
// range/size error reporting and registered read data
module sram_ctrl_if_gen2
    import sram_ctrl_pkg::*;
#(
    parameter int AHB_DWIDTH = 32,
    parameter int DEPTH      = 512,
    parameter int RD_LATENCY = 1
) (
    input  logic                              HCLK,
    input  logic                              HRESETN,
    input  logic                              ahbsram_req,
    input  logic                              ahbsram_write,
    input  logic [2:0]                        ahbsram_size,
    input  logic [19:0]                       ahbsram_addr,
    input  logic [AHB_DWIDTH-1:0]             ahbsram_wdata,
    output logic                              sramahb_ack,
    output logic                              sramahb_err,
    output logic [AHB_DWIDTH-1:0]             sramahb_rdata,
    output logic                              BUSY,
    output logic [AHB_DWIDTH/8-1:0]           mem_wen,
    output logic                              mem_ren,
    output logic [$clog2(DEPTH)-1:0]          mem_addr,
    output logic [AHB_DWIDTH-1:0]             mem_wdata,
    input  logic [AHB_DWIDTH-1:0]             mem_rdata,
    input  logic                              mem_busy
);
    localparam int NB = AHB_DWIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam int AW = $clog2(DEPTH);

    if (!params_legal(AHB_DWIDTH, DEPTH, RD_LATENCY)) begin : g_bad_params
        $error("sram_ctrl_if_gen2: illegal parameter set");
    end

    state_t                r_state;
    logic [1:0]            r_cnt;
    logic                  r_ack;
    logic                  r_err;
    logic [AHB_DWIDTH-1:0] r_rdata;
    logic [NB-1:0]         w_mask;
    logic                  w_size_err;
    logic                  w_range_err;
    logic                  w_err;
    logic                  w_issue;

    sram_lane_decode #(.NB(NB), .LB(LB)) u_lane (
        .i_size     (ahbsram_size),
        .i_off      (ahbsram_addr[LB-1:0]),
        .o_mask     (w_mask),
        .o_size_err (w_size_err)
    );

    assign w_range_err = (32'(ahbsram_addr) >> LB) >= 32'(DEPTH);
    assign w_err       = w_size_err || w_range_err;
    // strobes exist only in the IDLE issue cycle; busy holds the request off
    assign w_issue     = HRESETN && r_state == IDLE && ahbsram_req && !mem_busy;

    assign mem_wen       = (w_issue && ahbsram_write && !w_err) ? w_mask : '0;
    assign mem_ren       = w_issue && !ahbsram_write && !w_err;
    assign mem_addr      = ahbsram_addr[LB+AW-1:LB];
    assign mem_wdata     = ahbsram_wdata;
    assign BUSY          = mem_busy;
    assign sramahb_ack   = r_ack;
    assign sramahb_err   = r_err;
    assign sramahb_rdata = r_rdata;

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: if (w_issue) begin
                    r_state <= w_err ? ERR : (ahbsram_write ? WR : RD);
                    r_ack   <= w_err || ahbsram_write;
                    r_err   <= w_err;
                    r_cnt   <= '0;
                end
                WR, ERR: r_state <= IDLE;
                RD: begin
                    // count latency cycles; capture on the edge ending the valid cycle, ack next
                    r_cnt <= r_cnt + 2'd1;
                    if (32'(r_cnt) == RD_LATENCY - 1) begin
                        r_rdata <= mem_rdata;
                        r_ack   <= 1'b1;
                    end
                    if (32'(r_cnt) == RD_LATENCY) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_ctrl_if_gen2.sv
// tb_sram_ctrl_if_gen2: randomized check of a 32-bit/latency-1 and a 64-bit/latency-2 build
module tb_sram_ctrl_if_gen2;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int DW    = (g == 0) ? 32 : 64;
        localparam int LAT   = (g == 0) ? 1 : 2;
        localparam int NB    = DW / 8;
        localparam int LB    = $clog2(NB);
        localparam int DEPTH = 512;

        logic rst_n = 1'b1, req = 1'b0, wr = 1'b0, mbusy = 1'b0, load = 1'b0, done = 1'b0;
        logic [2:0]    size  = '0;
        logic [19:0]   addr  = '0;
        logic [DW-1:0] wdata = '0, ld = '0, last = '0;
        logic [DW-1:0] p1, p2, mrdata, rdata, mwdata;
        logic [8:0]    maddr, la = '0;
        logic [NB-1:0] wen;
        logic          ack, err, ren, busy_o;
        logic [DW-1:0] sram [DEPTH];
        logic [7:0]    refm [DEPTH*NB];

        sram_ctrl_if_gen2 #(.AHB_DWIDTH(DW), .DEPTH(DEPTH), .RD_LATENCY(LAT)) u_dut (
            .HCLK          (clk),
            .HRESETN       (rst_n),
            .ahbsram_req   (req),
            .ahbsram_write (wr),
            .ahbsram_size  (size),
            .ahbsram_addr  (addr),
            .ahbsram_wdata (wdata),
            .sramahb_ack   (ack),
            .sramahb_err   (err),
            .sramahb_rdata (rdata),
            .BUSY          (busy_o),
            .mem_wen       (wen),
            .mem_ren       (ren),
            .mem_addr      (maddr),
            .mem_wdata     (mwdata),
            .mem_rdata     (mrdata),
            .mem_busy      (mbusy)
        );

        // array model: data valid LAT cycles after ren, garbage otherwise
        always @(posedge clk) begin
            if (load) sram[la] <= ld;
            for (int b = 0; b < NB; b++)
                if (wen[b]) sram[maddr][b*8 +: 8] <= mwdata[b*8 +: 8];
            p1 <= ren ? sram[maddr] : DW'({$urandom, $urandom});
            p2 <= p1;
        end
        assign mrdata = (LAT == 1) ? p1 : p2;

        task automatic c(input string t, input logic [63:0] got, input logic [63:0] exp);
            chk($sformatf("cfg%0d %s", g, t), got, exp);
        endtask

        task automatic xfer(input logic w, input logic [2:0] s, input logic [19:0] a,
                            input logic [DW-1:0] d, input int nbusy);
            int bytes, al, lat;
            logic e;
            logic [NB-1:0] m;
            logic [DW-1:0] x;
            bytes = 1 << s;
            e  = (int'(s) > LB) || ((int'(a) >> LB) >= DEPTH);
            al = int'(a) & ~(bytes - 1);
            m  = '0;
            x  = last;
            if (!e && w) for (int b = 0; b < bytes; b++) m[(al % NB) + b] = 1'b1;
            if (!e && !w) for (int b = 0; b < NB; b++) x[b*8 +: 8] = refm[(int'(a) >> LB) * NB + b];
            @(negedge clk);
            req = 1'b1; wr = w; size = s; addr = a; wdata = d;
            for (int k = 0; k < nbusy; k++) begin
                mbusy = 1'b1;
                #1;
                c("busy_wen", wen, 0);
                c("busy_ren", ren, 0);
                c("busy_out", busy_o, 1);
                @(negedge clk);
            end
            mbusy = 1'b0;
            #1;
            c("ack_idle", ack, 0);
            c("wen", wen, m);
            c("ren", ren, !e && !w);
            if (!e) c("maddr", maddr, int'(a) >> LB);
            if (!e && w)
                for (int b = 0; b < bytes; b++) refm[al + b] = d[((al + b) % NB) * 8 +: 8];
            lat = (e || w) ? 1 : LAT + 1;
            for (int k = 1; k <= lat; k++) begin
                @(negedge clk);
                mbusy = 1'($urandom);
                #1;
                c("no_reissue", {wen, ren}, 0);
                if (k < lat) begin
                    c("early_ack", ack, 0);
                    c("rdata_hold", rdata, last);
                end
            end
            last = x;
            c("ack", ack, 1);
            c("err", err, e);
            c("rdata", rdata, last);
        endtask

        initial begin
            logic [DW-1:0] v;
            logic [2:0] s;
            logic [19:0] a;
            #1 rst_n = 1'b0;
            load = 1'b1;
            for (int w = 0; w < DEPTH; w++) begin
                v = (w == 5) ? DW'(32'hA5A55A5A) : DW'({$urandom, $urandom});
                la = 9'(w);
                ld = v;
                for (int b = 0; b < NB; b++) refm[w * NB + b] = v[b*8 +: 8];
                @(negedge clk);
            end
            load = 1'b0;
            #1;
            c("rst_ack", ack, 0);
            c("rst_err", err, 0);
            c("rst_rdata", rdata, 0);
            c("rst_wen", wen, 0);
            c("rst_ren", ren, 0);
            @(negedge clk);
            rst_n = 1'b1;
            if (g == 0) begin
                xfer(1'b1, 3'd2, 20'h010, DW'(32'hDEADBEEF), 0);
                xfer(1'b0, 3'd2, 20'h010, '0, 0);
                xfer(1'b1, 3'd2, 20'h800, DW'(32'h0BADF00D), 0);
                xfer(1'b0, 3'd2, 20'h800, '0, 0);
                xfer(1'b1, 3'd3, 20'h014, DW'(32'h55AA55AA), 0);
                xfer(1'b1, 3'd2, 20'h018, DW'(32'h12345678), 3);
                xfer(1'b0, 3'd2, 20'h018, '0, 3);
                xfer(1'b0, 3'd2, 20'h014, '0, 0);
            end else begin
                xfer(1'b1, 3'd0, 20'h020, DW'({8{8'h11}}), 0);
                xfer(1'b1, 3'd0, 20'h021, DW'({8{8'h22}}), 0);
                xfer(1'b1, 3'd0, 20'h022, DW'({8{8'h33}}), 0);
                xfer(1'b1, 3'd0, 20'h023, DW'({8{8'h44}}), 0);
                xfer(1'b1, 3'd1, 20'h026, DW'({4{16'hBEEF}}), 0);
                xfer(1'b0, 3'd3, 20'h020, '0, 0);
                xfer(1'b1, 3'd3, 20'h020, DW'(64'h0123456789ABCDEF), 0);
                xfer(1'b0, 3'd3, 20'h028, '0, 0);
                xfer(1'b0, 3'd3, 20'h020, '0, 0);
                xfer(1'b1, 3'd4, 20'h030, DW'({$urandom, $urandom}), 0);
                xfer(1'b0, 3'd3, 20'h1000, '0, 0);
                xfer(1'b0, 3'd3, 20'h028, '0, 3);
            end
            for (int i = 0; i < 8; i++)
                xfer(1'b0, 3'(LB), 20'($urandom_range(0, DEPTH * NB - 1)), '0, 0);
            for (int i = 0; i < 150; i++) begin
                s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(LB + 1, 7)) : 3'($urandom_range(0, LB));
                a = ($urandom_range(0, 9) == 0) ? 20'($urandom_range(DEPTH * NB, 20'hFFFFF))
                                                : 20'($urandom_range(0, DEPTH * NB - 1));
                if ($urandom_range(0, 3) == 0) begin
                    @(negedge clk);
                    req = 1'b0;
                end
                xfer(1'($urandom), s, a, DW'({$urandom, $urandom}), int'($urandom_range(0, 2)));
            end
            // reset while a read is in flight: ack dropped, late array data not captured
            @(negedge clk);
            req = 1'b1; wr = 1'b0; size = 3'(LB); addr = 20'h040; mbusy = 1'b0;
            #1;
            c("rst_issue_ren", ren, 1);
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            c("rst_mid_ack", ack, 0);
            c("rst_mid_rdata", rdata, 0);
            req = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (k == 1) rst_n = 1'b1;
                #1;
                c("rst_after_ack", ack, 0);
                c("rst_after_rdata", rdata, 0);
            end
            last = '0;
            xfer(1'b0, 3'(LB), 20'h040, '0, 0);
            xfer(1'b1, 3'(LB), 20'h048, DW'({$urandom, $urandom}), 1);
            xfer(1'b0, 3'(LB), 20'h048, '0, 0);
            @(negedge clk);
            req = 1'b0;
            done = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 50000 && !(g_cfg[0].done && g_cfg[1].done); i++) @(posedge clk);
        chk("all_done", {62'd0, g_cfg[1].done, g_cfg[0].done}, 64'd3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
